// File: rtl/alu_word_sequencer_pkg.sv
// Shared encodings for the word sequencer and the N-bit ALU it drives.
package alu_word_sequencer_pkg;

  // ALU operation encodings; the external ALU decodes the same values.
  typedef enum logic [2:0] {
    MODE_ADD = 3'b000,
    MODE_SUB = 3'b001,
    MODE_AND = 3'b010,
    MODE_OR  = 3'b011,
    MODE_XOR = 3'b100,
    MODE_NOT = 3'b101,
    MODE_INC = 3'b110,
    MODE_DEC = 3'b111
  } mode_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Modes whose words are linked by a carry/borrow chain.
  function automatic logic is_chained(input mode_e m);
    return (m == MODE_ADD) || (m == MODE_SUB) || (m == MODE_INC) || (m == MODE_DEC);
  endfunction

endpackage

// File: rtl/alu_word_sequencer_if.sv
// Request/response bus plus the word-wide ALU link of the sequencer.
interface alu_word_sequencer_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  // request side
  logic         start;
  logic [2:0]   mode;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cb_in;

  // ALU link
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cb_in;
  logic [2:0]   alu_mode;
  logic [N-1:0] alu_result;
  logic         alu_cb_out;

  // response side
  logic [W-1:0] result;
  logic         cb_out;
  logic         zero;
  logic         busy;
  logic         done;

  // Sequencer view.
  modport slave (
    input  start, mode, op_a, op_b, cb_in, alu_result, alu_cb_out,
    output alu_a, alu_b, alu_cb_in, alu_mode, result, cb_out, zero, busy, done
  );

  // Environment view: requester plus the ALU.
  modport master (
    output start, mode, op_a, op_b, cb_in, alu_result, alu_cb_out,
    input  alu_a, alu_b, alu_cb_in, alu_mode, result, cb_out, zero, busy, done
  );

endinterface

// File: rtl/alu_word_sequencer.sv
// Multi-word sequencer: runs a W-bit operation through an external N-bit ALU,
// one word per cycle, chaining carry/borrow between words.
module alu_word_sequencer
  import alu_word_sequencer_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_word_sequencer_if.slave bus
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e           state;
  state_e           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  mode_e            mode_q;
  logic             cb_in_q;
  logic [W-1:0]     result_q;
  logic [W-1:0]     result_nxt;
  logic             cb_out_q;
  logic             zero_q;
  logic             last_word;
  logic             first_word;

  assign last_word  = (idx == IDX_W'(WORDS - 1));
  assign first_word = (idx == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result with the current ALU word merged in at idx.
  always_comb begin
    result_nxt = result_q;
    result_nxt[idx*N +: N] = bus.alu_result;
  end

  // Operand latch, word index, carry chain and result collection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_ADD;
      cb_in_q  <= 1'b0;
      result_q <= '0;
      cb_out_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            mode_q  <= mode_e'(bus.mode);
            cb_in_q <= bus.cb_in;
            idx     <= '0;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          carry    <= bus.alu_cb_out;
          if (last_word) begin
            // Flags land together with the DONE cycle so they are valid alongside done.
            cb_out_q <= is_chained(mode_q) ? bus.alu_cb_out : 1'b0;
            zero_q   <= (result_nxt == '0);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status and ALU drive; the ALU sees zeros outside RUN.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_cb_in = 1'b0;
    bus.alu_mode  = MODE_ADD;
    if (state == RUN) begin
      bus.alu_a = a_q[idx*N +: N];
      case (mode_q)
        MODE_ADD, MODE_SUB: begin
          bus.alu_mode  = mode_q;
          bus.alu_b     = b_q[idx*N +: N];
          bus.alu_cb_in = first_word ? cb_in_q : carry;
        end
        // Increment/decrement become add/sub of zero with a forced carry-in,
        // so the +/-1 ripples across every word.
        MODE_INC: begin
          bus.alu_mode  = MODE_ADD;
          bus.alu_cb_in = first_word ? 1'b1 : carry;
        end
        MODE_DEC: begin
          bus.alu_mode  = MODE_SUB;
          bus.alu_cb_in = first_word ? 1'b1 : carry;
        end
        default: begin
          bus.alu_mode = mode_q;
          bus.alu_b    = b_q[idx*N +: N];
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.cb_out = cb_out_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer (N=4, WORDS=4) with a behavioural ALU attached.
module tb_alu_word_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [4:0] alu_t;

  alu_word_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  alu_word_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU; sub/dec report borrow on cb_out.
  always_comb begin
    alu_t = 5'd0;
    case (bus.alu_mode)
      3'b000:  alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cb_in};
      3'b001:  alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'd0, bus.alu_cb_in};
      3'b010:  alu_t = {1'b0, bus.alu_a & bus.alu_b};
      3'b011:  alu_t = {1'b0, bus.alu_a | bus.alu_b};
      3'b100:  alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
      3'b101:  alu_t = {1'b0, ~bus.alu_a};
      3'b110:  alu_t = {1'b0, bus.alu_a} + 5'd1;
      default: alu_t = {1'b0, bus.alu_a} - 5'd1;
    endcase
    bus.alu_result = alu_t[3:0];
    bus.alu_cb_out = alu_t[4];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] m, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input logic [2:0] exp_amode,
                        input logic exp_acb, input logic [15:0] exp_res,
                        input logic exp_cb, input logic exp_z);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.op_a = a; bus.op_b = b; bus.cb_in = ci;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"},  32'(bus.busy), 32'd1);
    chk({tag, "_amode"}, 32'(bus.alu_mode), 32'(exp_amode));
    chk({tag, "_acb"},   32'(bus.alu_cb_in), 32'(exp_acb));
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"},  32'(cyc), 32'd5);
    chk({tag, "_res"},  32'(bus.result), 32'(exp_res));
    chk({tag, "_cb"},   32'(bus.cb_out), 32'(exp_cb));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(exp_z));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'({bus.busy, bus.done}), 32'd0);
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.start = 1'b0; bus.mode = 3'b000; bus.op_a = 16'h0; bus.op_b = 16'h0; bus.cb_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags",  32'({bus.cb_out, bus.zero, bus.busy, bus.done}), 32'd0);
    rst_n = 1'b1;
    bus.op_a = 16'h1234; bus.op_b = 16'h5678;
    @(negedge clk);
    chk("idle_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cb_in, bus.alu_mode}), 32'd0);

    run_op("add",  3'b000, 16'hFFFF, 16'h0001, 1'b0, 3'b000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("sub1", 3'b001, 16'h0000, 16'h0001, 1'b0, 3'b001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("sub2", 3'b001, 16'h1234, 16'h0234, 1'b1, 3'b001, 1'b1, 16'h0FFF, 1'b0, 1'b0);
    run_op("inc",  3'b110, 16'h00FF, 16'h5555, 1'b0, 3'b000, 1'b1, 16'h0100, 1'b0, 1'b0);
    run_op("dec",  3'b111, 16'h0000, 16'h5555, 1'b0, 3'b001, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("xor",  3'b100, 16'hA5A5, 16'hFFFF, 1'b1, 3'b100, 1'b0, 16'h5A5A, 1'b0, 1'b0);
    run_op("not",  3'b101, 16'hFFFF, 16'h1234, 1'b1, 3'b101, 1'b0, 16'h0000, 1'b0, 1'b1);

    // start held high for two operations; operands altered mid-run
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 3'b000; bus.op_a = 16'h0001; bus.op_b = 16'h0001; bus.cb_in = 1'b0;
    dones = 0; first_done = 0; second_done = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.op_a = 16'hFFFF; bus.op_b = 16'hFFFF; end
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          first_done = i;
          chk("hold_res1", 32'(bus.result), 32'h0002);
          chk("hold_cb1",  32'(bus.cb_out), 32'd0);
        end else if (dones == 2) begin
          second_done = i;
          chk("hold_res2", 32'(bus.result), 32'hFFFE);
          chk("hold_cb2",  32'(bus.cb_out), 32'd1);
        end
      end
    end
    bus.start = 1'b0;
    chk("hold_dones",  32'(dones), 32'd2);
    chk("hold_first",  32'(first_done), 32'd5);
    chk("hold_second", 32'(second_done), 32'd11);

    // reset in the second RUN cycle aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 16'h1111; bus.op_b = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_flags",  32'({bus.cb_out, bus.zero, bus.busy, bus.done}), 32'd0);
    chk("abort_alu",    32'({bus.alu_a, bus.alu_b, bus.alu_cb_in, bus.alu_mode}), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op("post_rst", 3'b000, 16'h0003, 16'h0004, 1'b0, 3'b000, 1'b0, 16'h0007, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_word_sequencer.md
Name: alu_word_sequencer

Overview:
- Multi-word arithmetic/logic sequencer. It drives the team's N-bit combinational ALU one word per cycle and captures that ALU's Result/CB_out, building a WORDS*N-bit operation from N-bit slices.
- It sits both upstream of the ALU (operands, mode, carry-in) and downstream of it (result collection, carry/borrow chaining, flags).
- It lets the narrow ALU serve wide datapaths without widening the ALU itself.

Parameters:
- N, 4, ALU word width in bits; must match the ALU instance's N.
- WORDS, 4, number of N-bit words per operation; must be >= 1. Total width W = N*WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  3  operation; ALU encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 inc A, 111 dec A.
- op_a  in  W  operand A.
- op_b  in  W  operand B (ignored for 101/110/111).
- cb_in  in  1  carry/borrow in (add/sub only).
- alu_a  out  N  word of A to ALU.
- alu_b  out  N  word of B to ALU.
- alu_cb_in  out  1  carry/borrow to ALU.
- alu_mode  out  3  mode to ALU.
- alu_result  in  N  ALU Result.
- alu_cb_out  in  1  ALU CB_out.
- result  out  W  assembled result.
- cb_out  out  1  final carry/borrow.
- zero  out  1  result == 0.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, carry=0.
  - All latched operand registers cleared.
  - result=0, cb_out=0, zero=0, busy=0, done=0.
  - alu_* outputs all 0.
  - Reset mid-operation aborts it with no done pulse.
- States:
  - IDLE: start=1 latches op_a, op_b, mode, and cb_in; sets idx=0 and moves to RUN. start=0 stays in IDLE.
  - RUN: each cycle writes alu_result into result[idx*N +: N]. If idx==WORDS-1, moves to DONE; else idx+1.
  - DONE: done=1 for exactly this cycle; cb_out and zero are updated; then returns to IDLE.
- Latency:
  - start sampled at edge 0, so RUN occupies cycles 1..WORDS and done is high in cycle WORDS+1.
  - Throughput is one operation per WORDS+2 cycles.
- start outside IDLE is ignored; requests are neither queued nor errored.
- ALU drive:
  - alu_a and alu_b are combinational slices of the latched operands at idx.
  - In IDLE and DONE, alu_a=0, alu_b=0, alu_cb_in=0, alu_mode=000.
- Mode translation in RUN:
  - 000/001: alu_mode = latched mode. alu_cb_in = latched cb_in at idx 0, then the carry register.
  - 110 inc: alu_mode=000, alu_b=0, alu_cb_in=1 at idx 0, then carry. This gives a full-width carry chain.
  - 111 dec: alu_mode=001, alu_b=0, alu_cb_in=1 at idx 0, then carry (borrow chain).
  - 010..101: alu_mode = latched mode, alu_cb_in=0; words are independent.
- Carry register:
  - Loads alu_cb_out every RUN cycle.
  - cb_out = carry after the last word for add/sub/inc/dec; cb_out = 0 for logic modes.
- Hold behaviour: result, cb_out, and zero hold until the next accepted start.
  - result words are overwritten progressively during RUN.
  - cb_out and zero change only in DONE.
- zero is evaluated on the complete W-bit result in DONE.
- WORDS=1: idx register width is 1 bit; a single RUN cycle.

Decomposition:
- Shared package: mode encodings (MODE_ADD..MODE_DEC) and the state encoding IDLE/RUN/DONE.
- Both the ALU and this block use the package constants.
- No sub-module. The ALU stays external and is wired by the parent, so the sequencer is testable against the real ALU or a model.

Test Plan:
All cases use N=4, WORDS=4 with the real ALU instance attached.
- add: op_a=0xFFFF, op_b=0x0001, cb_in=0 -> done in cycle 5; result=0x0000, cb_out=1, zero=1.
- sub: op_a=0x0000, op_b=0x0001, cb_in=0 -> result=0xFFFF, cb_out=1, zero=0. Also op_a=0x1234, op_b=0x0234, cb_in=1 -> result=0x0FFF, cb_out=0.
- inc: op_a=0x00FF -> 0x0100, cb_out=0. dec: op_a=0x0000 -> 0xFFFF, cb_out=1. Check alu_mode is 000 for inc and 001 for dec during RUN.
- xor: 0xA5A5 with 0xFFFF -> 0x5A5A, cb_out=0. not: op_a=0xFFFF -> 0x0000, zero=1, cb_out=0.
- start held high through an operation -> exactly one done per WORDS+2 cycles. Operands changed mid-run do not affect the result.
- rst_n low in cycle 2 of RUN -> all outputs 0 immediately with no done pulse. After release, a new add 0x0003+0x0004 -> 0x0007.
